// File: rtl/spi_slave_ram_crc.sv
// SPI mode-0 slave with a word-addressed register RAM and CRC-8 framed access.
// All SPI pins are oversampled in the clk domain; writes commit only on a CRC match.
module spi_slave_ram_crc #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DEPTH      = 32,
  parameter logic [7:0]            CRC_POLY   = 8'h1D,
  parameter logic [7:0]            CRC_INIT   = 8'hFF,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD0 = 24'hFEDCBA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       csn,
  input  logic       si,
  output logic       so,
  output logic       busy,
  output logic       frame_done,
  output logic       wr_ok,
  output logic       crc_err,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] CRC   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC_POLY : 8'h00);
  endfunction

  logic [2:0]            sck_q_r;
  logic [2:0]            csn_q_r;
  logic [1:0]            si_q_r;
  logic [2:0]            state_r;
  logic [5:0]            bit_cnt_r;
  logic [7:0]            cmd_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [7:0]            crc_r;
  logic [6:0]            crc_rx_r;
  logic                  so_r;
  logic                  busy_r;
  logic                  frame_done_r;
  logic                  wr_ok_r;
  logic                  crc_err_r;
  logic [7:0]            err_cnt_r;
  logic                  wr_en_r;
  // Word 0 is stored XOR-ed with INIT_WORD0 so that cleared cells read back as the power-up value.
  logic [DATA_WIDTH-1:0] ram_r [DEPTH];

  logic                  sck_rise_s, sck_fall_s, csn_fall_s, csn_rise_s, si_s;
  logic                  is_wr_s, in_range_s, data_bit_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] mask_s, ram_rd_s;
  logic [7:0]            crc_next_s;

  assign sck_rise_s = sck_q_r[1] & ~sck_q_r[2];
  assign sck_fall_s = ~sck_q_r[1] & sck_q_r[2];
  assign csn_fall_s = ~csn_q_r[1] & csn_q_r[2];
  assign csn_rise_s = csn_q_r[1] & ~csn_q_r[2];
  assign si_s       = si_q_r[1];
  assign is_wr_s    = cmd_r[7];
  assign addr_s     = cmd_r[ADDR_WIDTH-1:0];
  assign in_range_s = (32'(addr_s) < 32'(DEPTH));
  assign mask_s     = (addr_s == {ADDR_WIDTH{1'b0}}) ? INIT_WORD0 : {DATA_WIDTH{1'b0}};
  assign ram_rd_s   = in_range_s ? (ram_r[addr_s] ^ mask_s) : {DATA_WIDTH{1'b0}};
  assign data_bit_s = is_wr_s ? si_s : shift_r[DATA_WIDTH-1];
  assign crc_next_s = crc8_step(crc_r, data_bit_s);

  // Two-stage synchronisers plus one edge-detect register per SPI pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q_r <= 3'b000;
      csn_q_r <= 3'b111;
      si_q_r  <= 2'b00;
    end else begin
      sck_q_r <= {sck_q_r[1:0], sck};
      csn_q_r <= {csn_q_r[1:0], csn};
      si_q_r  <= {si_q_r[0], si};
    end
  end

  // Frame state machine, shift/CRC datapath and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 6'd0;
      cmd_r        <= 8'h00;
      shift_r      <= {DATA_WIDTH{1'b0}};
      crc_r        <= 8'h00;
      crc_rx_r     <= 7'd0;
      so_r         <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      wr_ok_r      <= 1'b0;
      crc_err_r    <= 1'b0;
      err_cnt_r    <= 8'h00;
      wr_en_r      <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      wr_ok_r      <= 1'b0;
      crc_err_r    <= 1'b0;
      if (csn_rise_s && (state_r != IDLE) && (state_r != DONE)) begin
        state_r <= IDLE;
        so_r    <= 1'b0;
        busy_r  <= 1'b0;
        wr_en_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            so_r <= 1'b0;
            if (csn_fall_s) begin
              state_r   <= CMD;
              bit_cnt_r <= 6'd0;
              crc_r     <= CRC_INIT;
              busy_r    <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise_s) begin
              cmd_r <= {cmd_r[6:0], si_s};
              crc_r <= crc8_step(crc_r, si_s);
              if (bit_cnt_r == 6'd7) begin
                bit_cnt_r <= 6'd0;
                state_r   <= cmd_r[6] ? DATA : FETCH;
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
              end
            end
          end
          FETCH: begin
            shift_r <= ram_rd_s;
            so_r    <= ram_rd_s[DATA_WIDTH-1];
            state_r <= DATA;
          end
          DATA: begin
            if (sck_rise_s) begin
              crc_r <= crc_next_s;
              if (bit_cnt_r == 6'(DATA_WIDTH - 1)) begin
                bit_cnt_r <= 6'd0;
                state_r   <= CRC;
                // A read reuses the shift register to send the CRC MSB-first.
                shift_r   <= is_wr_s ? {shift_r[DATA_WIDTH-2:0], si_s}
                                     : (DATA_WIDTH'(crc_next_s) << (DATA_WIDTH - 8));
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                shift_r   <= {shift_r[DATA_WIDTH-2:0], si_s};
              end
            end else if (sck_fall_s && !is_wr_s) begin
              so_r <= shift_r[DATA_WIDTH-1];
            end
          end
          CRC: begin
            if (sck_rise_s) begin
              crc_rx_r <= {crc_rx_r[5:0], si_s};
              if (!is_wr_s) begin
                shift_r <= shift_r << 1;
              end
              if (bit_cnt_r == 6'd7) begin
                state_r      <= DONE;
                frame_done_r <= 1'b1;
                if (is_wr_s && ({crc_rx_r, si_s} == crc_r)) begin
                  wr_ok_r <= 1'b1;
                  wr_en_r <= in_range_s;
                end else if (is_wr_s) begin
                  crc_err_r <= 1'b1;
                  if (err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                  end
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
              end
            end else if (sck_fall_s && !is_wr_s) begin
              so_r <= shift_r[DATA_WIDTH-1];
            end
          end
          DONE: begin
            so_r    <= 1'b0;
            busy_r  <= 1'b0;
            wr_en_r <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            so_r    <= 1'b0;
            busy_r  <= 1'b0;
            wr_en_r <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // RAM write port; contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (wr_en_r && (state_r == DONE)) begin
      ram_r[addr_s] <= shift_r ^ mask_s;
    end
  end

  assign so         = so_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign wr_ok      = wr_ok_r;
  assign crc_err    = crc_err_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: doc/spi_slave_ram_crc.md
# spi_slave_ram_crc

Parametrised SPI slave (mode 0) with an internal word-addressed register RAM and CRC-8 frame protection; successor to the fixed 24-bit single-word SPI slave. A master selects a RAM word by a command byte, then reads or writes a DATA_WIDTH-bit word followed by a CRC-8 byte. All SPI pins are oversampled in the `clk` domain, so the block has one clock. Writes reach RAM only when the received CRC matches. It sits between the chip-level SPI pads and the configuration/status logic.

## Interface
- `DATA_WIDTH`, 24: data word width in bits; multiple of 8, range 8..32.
- `ADDR_WIDTH`, 5: RAM address width, 1..7.
- `DEPTH`, 32: number of RAM words, ≤ 2**ADDR_WIDTH.
- `CRC_POLY`, 8'h1D: CRC-8 polynomial (SAE-J1850 default).
- `CRC_INIT`, 8'hFF: CRC preset value.
- `INIT_WORD0`, 24'hFEDCBA: power-up content of word 0. All other words power up as 0.
- `clk` in 1: system clock. Frequency ≥ 8× sck.
- `rst` in 1: **synchronous, active-high** reset.
- `sck` in 1: SPI clock, asynchronous to `clk`.
- `csn` in 1: chip select, active low, asynchronous.
- `si` in 1: MOSI.
- `so` out 1: MISO. Driven low whenever not transmitting.
- `busy` out 1: high while a frame is in progress.
- `frame_done` out 1: one-cycle pulse when a complete frame ends.
- `wr_ok` out 1: one-cycle pulse when a CRC-valid write commits.
- `crc_err` out 1: one-cycle pulse when a write CRC mismatches.
- `err_cnt` out 8: saturating count of CRC errors.

## Operation
- **Input synchronisation**
  - `sck`, `csn` and `si` each pass through a 2-FF synchroniser.
  - Rising and falling edges of `sck` are detected in the `clk` domain.
- **Frame format** (MSB first on both lines):
  - Command byte: bit7 = 1 for write, 0 for read. Bits[ADDR_WIDTH-1:0] are the address; the remaining bits are ignored.
  - Then DATA_WIDTH data bits, then 8 CRC bits.
  - `si` is sampled on sck rise; `so` changes on sck fall.
- **CRC**
  - MSB-first, preset CRC_INIT, no reflection, no final XOR.
  - Covers the command byte plus the data word.
- **States**: IDLE, CMD, FETCH, DATA, CRC, DONE.
  - IDLE: on `csn` falling, clear bit counter, preset CRC, go to CMD.
  - CMD: shift 8 bits into the command register.
    - Read → FETCH.
    - Write → DATA.
    - Address ≥ DEPTH: a read returns all-zero data; a write is discarded but still CRC-checked and reported.
  - FETCH: one `clk` synchronous RAM read, load the shift register, present its MSB on `so`. Then go to DATA.
  - DATA:
    - Write: shift DATA_WIDTH bits in from `si`.
    - Read: shift the word out; the next bit goes on `so` at each sck fall.
    - Both directions: the CRC is updated per bit.
    - After the last data bit → CRC.
  - CRC:
    - Read: transmit the computed CRC.
    - Write: receive 8 bits into `crc_rx`.
    - After the 8th sampled bit → DONE.
  - DONE, one clk:
    - Write with `crc_rx` == computed CRC: write RAM, pulse `wr_ok`.
    - Write with a mismatch: no RAM write, pulse `crc_err`, `err_cnt` += 1, saturating at 255.
    - Always pulse `frame_done`, then go to IDLE.
    - Further sck edges are ignored until `csn` rises; a new frame needs a `csn` high→low transition.
- **Abort**: `csn` rising in any state other than IDLE/DONE returns to IDLE.
  - No RAM write and no status pulses.
  - `so` goes to 0.

## Timing
- **Reset values**: `so`=0, `busy`=0, `frame_done`=0, `wr_ok`=0, `crc_err`=0, `err_cnt`=0, state IDLE, shift/CRC registers cleared.
  - RAM contents are not affected by `rst`.
  - Reset mid-frame aborts the frame silently.
- **Pad-to-logic latency**: 3 clk (2 synchroniser stages + edge register).
- `busy` rises 3 clk after `csn` falls and drops in the cycle after DONE or abort.
- **Read first bit**: `so` carries data MSB ≤ 3 clk after the 8th command sck rise is detected, i.e. before the next sck fall when clk ≥ 8× sck.
- **RAM write**: takes effect on the clk edge ending DONE, which is 4 clk after the final CRC sck rise at the pad.
- A read immediately after a write to the same address returns the new data.
- `frame_done`, `wr_ok` and `crc_err` are single-cycle pulses, coincident in the DONE cycle.
- `err_cnt` updates on the same edge as the `crc_err` pulse.

## Test plan
- **Power-up read**: reset, read addr 0 (cmd 0x00) → `so` returns 0xFEDCBA followed by the CRC-8 of {0x00,0xFEDCBA} from the bench model; `frame_done` pulses once; `wr_ok`=`crc_err`=0.
- **Valid write then read-back**: write 0x123456 to addr 5 with the correct CRC → `wr_ok` pulse; a subsequent read of addr 5 returns 0x123456 plus the matching CRC.
- **Corrupted CRC**: write 0xA5A5A5 to addr 5 with CRC bit0 flipped → `crc_err` pulse, `err_cnt`=1, read of addr 5 still returns 0x123456.
- **Saturation**: 260 bad-CRC writes → `err_cnt`=255, with no wrap to 0.
- **Abort**: raise `csn` after 20 bits of a write to addr 3 → no pulses, addr 3 unchanged (0), `busy`=0, and the next complete frame works normally.
- **Out of range**: with DEPTH=20, read addr 25 → data 0 plus a valid CRC; write addr 25 → no RAM change, `wr_ok` still pulses if the CRC is correct. Also rerun the first scenario with DATA_WIDTH=16, INIT_WORD0=16'hBEEF.
